fdiv_round_pack: RTL and testbench
==================================

Name: fdiv_round_pack

Overview:
- Post-processing stage directly downstream of the Goldschmidt divider in the single-precision FP divide path.
- Captures the raw fixed-point quotient when the divider signals ready, together with the sign, exponent and special-case class from the operand stage.
- Normalises, rounds to nearest-even, detects overflow and underflow (flush-to-zero) and packs an IEEE-754 binary32 result.
- Presents the result on a valid/ready output handshake.

Parameters:
- EXP_W, 8, packed exponent width.
- FRAC_W, 23, packed fraction width.
- Q_W, 32, divider quotient width, unsigned 2.(Q_W-2) fixed point; requires Q_W >= FRAC_W+4.

Ports:
- clk  in  1  clock, rising edge.
- clrn  in  1  synchronous active-low reset.
- q_ready  in  1  divider quotient valid; sampled only in IDLE.
- q_mant  in  Q_W  quotient magnitude, value in [0.5,2); bit Q_W-1 weights 2, bit Q_W-2 weights 1.
- q_exp  in  EXP_W+2  signed biased exponent: ea - eb + bias, before normalisation.
- q_sign  in  1  result sign, signA xor signB.
- q_special  in  2  class: 00 normal, 01 zero, 10 infinity, 11 NaN.
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  packed binary32.
- flags  out  3  {ovf, unf, nx}.

Behaviour:
- Reset: clrn low at a rising edge puts the FSM in IDLE and clears busy, out_valid, result and flags. This applies from any state and discards any in-flight operation.
- IDLE
  - q_ready=1: register q_mant, q_exp, q_sign and q_special, then go to NORM.
  - Otherwise stay in IDLE.
- q_ready in any state other than IDLE is ignored. There is no queueing.
- NORM
  - If bit Q_W-2 is clear, shift the mantissa left 1 and decrement the exponent.
  - Bit Q_W-1 is never set for legal input. If it is set, shift right 1 (OR the lost bit into sticky) and increment the exponent.
  - Then go to ROUND.
- ROUND
  - Fraction = bits [Q_W-3 : Q_W-2-FRAC_W].
  - Guard = next lower bit. Sticky = OR of all remaining bits.
  - Round-to-nearest-even: increment if guard & (sticky | fraction LSB).
  - Fraction carry-out zeroes the fraction and increments the exponent.
  - nx = guard | sticky.
  - Then go to PACK.
- PACK (priority order)
  - NaN: result = 7FC00000 (canonical quiet NaN, sign ignored); flags = 000.
  - Infinity: result = {sign, all-ones exponent, 0}; flags = 000.
  - Zero: result = {sign, 0}; flags = 000.
  - Exponent >= 2^EXP_W - 1: result = signed infinity; ovf=1, nx=1.
  - Exponent <= 0: result = signed zero (no subnormals); unf=1, nx=1.
  - Else: result = {sign, exp[EXP_W-1:0], fraction}; flags = {0, 0, nx}.
  - Register result and flags, then go to DONE.
- DONE
  - out_valid=1. result and flags are held stable while out_ready=0.
  - The handshake completes at the edge where out_valid and out_ready are both 1; next state is IDLE.
  - A new capture is possible at the earliest on the edge after returning to IDLE.
- Latency: capture at edge E gives out_valid high after edge E+3, i.e. 3 cycles with 1 cycle per state.
- Exponent arithmetic is EXP_W+2 signed throughout and never wraps within legal input range.

Decomposition:
- Shared package fdiv_pkg:
  - FSM state enum {IDLE, NORM, ROUND, PACK, DONE}.
  - special-class enum.
  - BIAS = 127, QNAN = 32'h7FC00000, EXP_MAX = 255.
  - flag bit indices.
- One natural sub-module: fdiv_rne_round. It is combinational and performs fraction/guard/sticky extraction, the RNE increment and carry-out. It is instantiated in the ROUND stage.

Test Plan:
- q_mant=60000000, q_exp=127, sign 0, normal (3.0/2.0) -> result 3FC00000, flags 000, out_valid 3 cycles after capture.
- q_mant=30000000, q_exp=128 (needs left shift) -> result 3FC00000, flags 000.
- q_mant=7FFFFFFF, q_exp=127 -> round-up carry: result 40000000, nx=1. Same with q_exp=254 -> result 7F800000, flags 101.
- q_mant=40000000, q_exp=0, sign 1 -> result 80000000, flags 011. Also: q_special=11 -> 7FC00000; q_special=01 with sign 1 -> 80000000.
- Backpressure: out_ready low 5 cycles in DONE -> result and out_valid stable; second q_ready pulse during busy is ignored; out_ready=1 -> IDLE next cycle.
- clrn low during ROUND -> next cycle IDLE, busy=0, out_valid=0, result=0; no output for that operation.

Source files
------------

// File: rtl/fdiv_pkg.sv
// Shared types and constants for the FP divide post-processing stage.
// Covers the FSM states, special-operand classes, binary32 constants and flag positions.
package fdiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        ROUND = 3'd2,
        PACK  = 3'd3,
        DONE  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'b00,
        SP_ZERO   = 2'b01,
        SP_INF    = 2'b10,
        SP_NAN    = 2'b11
    } special_e;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam int          EXP_MAX = 255;

    // Bit positions inside the {ovf, unf, nx} flag vector.
    localparam int FLAG_OVF = 2;
    localparam int FLAG_UNF = 1;
    localparam int FLAG_NX  = 0;

endpackage

// File: rtl/fdiv_round_pack_if.sv
// Quotient-capture and result-handshake bundle between the divider, this stage and the consumer.
// master drives the quotient and out_ready; slave is the round/pack stage.
interface fdiv_round_pack_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int Q_W    = 32
);
    logic             q_ready;
    logic [Q_W-1:0]   q_mant;
    logic [EXP_W+1:0] q_exp;
    logic             q_sign;
    logic [1:0]       q_special;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic [2:0]       flags;

    modport master (
        output q_ready, q_mant, q_exp, q_sign, q_special, out_ready,
        input  busy, out_valid, result, flags
    );

    modport slave (
        input  q_ready, q_mant, q_exp, q_sign, q_special, out_ready,
        output busy, out_valid, result, flags
    );
endinterface

// File: rtl/fdiv_rne_round.sv
// Combinational round-to-nearest-even on a normalised quotient (bit Q_W-2 is the hidden one).
// Takes only the bits below the hidden one, plus any sticky bit already shifted out.
module fdiv_rne_round #(
    parameter int FRAC_W = 23,
    parameter int Q_W    = 32
) (
    input  logic [Q_W-3:0]    mant,
    input  logic              sticky_in,
    output logic [FRAC_W-1:0] frac,
    output logic              carry,
    output logic              nx
);
    localparam int LOW_W = Q_W - 3 - FRAC_W;

    logic [FRAC_W-1:0] frac_raw_s;
    logic              guard_s;
    logic              sticky_s;
    logic              inc_s;
    logic [FRAC_W:0]   sum_s;

    assign frac_raw_s = mant[Q_W-3 -: FRAC_W];
    assign guard_s    = mant[LOW_W];
    assign sticky_s   = (|mant[LOW_W-1:0]) | sticky_in;
    assign inc_s      = guard_s & (sticky_s | frac_raw_s[0]);
    // A carry out of the fraction leaves the low bits at zero, which is the required result.
    assign sum_s      = {1'b0, frac_raw_s} + {{FRAC_W{1'b0}}, inc_s};
    assign frac       = sum_s[FRAC_W-1:0];
    assign carry      = sum_s[FRAC_W];
    assign nx         = guard_s | sticky_s;
endmodule

// File: rtl/fdiv_round_pack.sv
// Normalise, round (RNE), range-check and pack a Goldschmidt quotient into binary32.
// One state per step: capture -> NORM -> ROUND -> PACK -> DONE, then valid/ready handoff.
module fdiv_round_pack
    import fdiv_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int Q_W    = 32
) (
    input logic              clk,
    input logic              clrn,
    fdiv_round_pack_if.slave bus
);
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_OVF  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = XW'(0);

    state_e                state_r;
    state_e                state_n;
    logic                  busy_r;
    logic                  out_valid_r;
    logic [Q_W-1:0]        mant_r;
    logic signed [XW-1:0]  exp_r;
    logic                  sign_r;
    special_e              special_r;
    logic                  sticky_r;
    logic [FRAC_W-1:0]     frac_r;
    logic                  nx_r;
    logic [31:0]           result_r;
    logic [2:0]            flags_r;
    logic [31:0]           pack_result_s;
    logic [2:0]            pack_flags_s;
    logic [FRAC_W-1:0]     rnd_frac_s;
    logic                  rnd_carry_s;
    logic                  rnd_nx_s;

    fdiv_rne_round #(.FRAC_W(FRAC_W), .Q_W(Q_W)) u_rne (
        .mant      (mant_r[Q_W-3:0]),
        .sticky_in (sticky_r),
        .frac      (rnd_frac_s),
        .carry     (rnd_carry_s),
        .nx        (rnd_nx_s)
    );

    // Next-state logic; q_ready only matters in IDLE.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (bus.q_ready) state_n = NORM; else state_n = IDLE;
            NORM:    state_n = ROUND;
            ROUND:   state_n = PACK;
            PACK:    state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE; else state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // State register with busy/out_valid registered from the next state.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            busy_r      <= (state_n != IDLE);
            out_valid_r <= (state_n == DONE);
        end
    end

    // Special classes win over range checks; range checks win over the normal pack.
    always_comb begin
        pack_result_s = 32'h0000_0000;
        pack_flags_s  = 3'b000;
        case (special_r)
            SP_NAN:  pack_result_s = QNAN;
            SP_INF:  pack_result_s = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            SP_ZERO: pack_result_s = {sign_r, {(EXP_W + FRAC_W){1'b0}}};
            default: begin
                if (exp_r >= EXP_OVF) begin
                    pack_result_s          = {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    pack_flags_s[FLAG_OVF] = 1'b1;
                    pack_flags_s[FLAG_NX]  = 1'b1;
                end else if (exp_r <= EXP_ZERO) begin
                    pack_result_s          = {sign_r, {(EXP_W + FRAC_W){1'b0}}};
                    pack_flags_s[FLAG_UNF] = 1'b1;
                    pack_flags_s[FLAG_NX]  = 1'b1;
                end else begin
                    pack_result_s         = {sign_r, exp_r[EXP_W-1:0], frac_r};
                    pack_flags_s[FLAG_NX] = nx_r;
                end
            end
        endcase
    end

    // Datapath: capture, normalise, round and pack, one step per state.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            mant_r    <= '0;
            exp_r     <= '0;
            sign_r    <= 1'b0;
            special_r <= SP_NORMAL;
            sticky_r  <= 1'b0;
            frac_r    <= '0;
            nx_r      <= 1'b0;
            result_r  <= 32'h0000_0000;
            flags_r   <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.q_ready) begin
                        mant_r    <= bus.q_mant;
                        exp_r     <= bus.q_exp;
                        sign_r    <= bus.q_sign;
                        special_r <= special_e'(bus.q_special);
                        sticky_r  <= 1'b0;
                    end
                end
                NORM: begin
                    // The top bit cannot be set for legal input; handle it without losing inexactness.
                    if (mant_r[Q_W-1]) begin
                        mant_r   <= {1'b0, mant_r[Q_W-1:1]};
                        sticky_r <= mant_r[0];
                        exp_r    <= exp_r + EXP_ONE;
                    end else if (!mant_r[Q_W-2]) begin
                        mant_r <= {mant_r[Q_W-2:0], 1'b0};
                        exp_r  <= exp_r - EXP_ONE;
                    end
                end
                ROUND: begin
                    frac_r <= rnd_frac_s;
                    nx_r   <= rnd_nx_s;
                    if (rnd_carry_s) begin
                        exp_r <= exp_r + EXP_ONE;
                    end
                end
                PACK: begin
                    result_r <= pack_result_s;
                    flags_r  <= pack_flags_s;
                end
                DONE: begin
                    result_r <= result_r;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.flags     = flags_r;
endmodule

// File: tb/tb_fdiv_round_pack.sv
// Self-checking bench for fdiv_round_pack: a value-level divide-result model plus a cycle-level
// handshake model drive one compare process; directed cases pin the model to literal results.
module tb_fdiv_round_pack;

    logic clk = 1'b0;
    logic clrn;
    always #5 clk = ~clk;

    fdiv_round_pack_if #(.EXP_W(8), .FRAC_W(23), .Q_W(32)) bus ();

    fdiv_round_pack #(.EXP_W(8), .FRAC_W(23), .Q_W(32)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: value = m * 2^(e - bias - 30); round the 24-bit significand by comparing the
    // discarded remainder with one half, then classify the final exponent. Returns {flags, result}.
    function automatic logic [34:0] ref_div(input logic [31:0] m, input int e,
                                            input logic s, input logic [1:0] sp);
        logic [31:0] mm;
        int ex;
        bit st;
        int sig;
        int rem;
        bit up;
        bit inx;
        if (sp == 2'b11) return {3'b000, 32'h7FC0_0000};
        if (sp == 2'b10) return {3'b000, s, 8'hFF, 23'h0};
        if (sp == 2'b01) return {3'b000, s, 31'h0};
        mm = m;
        ex = e;
        st = 1'b0;
        if (m[31]) begin
            st = m[0];
            mm = m >> 1;
            ex++;
        end else if (!m[30]) begin
            mm = m << 1;
            ex--;
        end
        sig = int'(mm >> 7);
        rem = int'(mm & 32'h0000_007F);
        inx = (rem != 0) || st;
        up  = (rem > 64) || ((rem == 64) && (st || (sig % 2 == 1)));
        sig = sig + int'(up);
        if (sig == (1 << 24)) begin
            sig = 1 << 23;
            ex++;
        end
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'h0};
        if (ex <= 0) return {3'b011, s, 31'h0};
        return {2'b00, inx, s, 8'(ex), 23'(sig)};
    endfunction

    // Cycle model: a capture in idle shows up 3 edges later and is held until accepted.
    int          ph = 0;
    int          n_acc = 0;
    logic [34:0] m_pend;
    logic [31:0] m_res;
    logic [2:0]  m_flags;

    always @(posedge clk) begin
        if (!clrn) begin
            ph      <= 0;
            m_res   <= 32'h0;
            m_flags <= 3'b000;
        end else begin
            case (ph)
                0: if (bus.q_ready) begin
                    m_pend <= ref_div(bus.q_mant, int'($signed(bus.q_exp)), bus.q_sign, bus.q_special);
                    ph     <= 1;
                    n_acc  <= n_acc + 1;
                end
                1, 2: ph <= ph + 1;
                3: begin
                    ph                <= 4;
                    {m_flags, m_res}  <= m_pend;
                end
                4: if (bus.out_ready) ph <= 0;
                default: ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", bus.busy, ph != 0);
            chk("out_valid", bus.out_valid, ph == 4);
            chk("result", bus.result, m_res);
            chk("flags", bus.flags, m_flags);
        end
    end

    task automatic drive(input logic [31:0] m, input int e, input logic s, input logic [1:0] sp);
        bus.q_mant    = m;
        bus.q_exp     = 10'(e);
        bus.q_sign    = s;
        bus.q_special = sp;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", n < 20, 1'b1);
    endtask

    task automatic op(input logic [31:0] m, input int e, input logic s, input logic [1:0] sp,
                      input logic [31:0] er, input logic [2:0] ef);
        int n;
        @(negedge clk);
        drive(m, e, s, sp);
        bus.q_ready   = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.q_ready = 1'b0;
        wait_valid(n);
        chk("latency", n, 3);
        chk("dir_result", bus.result, er);
        chk("dir_flags", bus.flags, ef);
        @(negedge clk);
        chk("idle_after", bus.busy, 1'b0);
    endtask

    initial begin
        int n;
        int acc0;
        int e;
        clrn          = 1'b0;
        bus.q_ready   = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'h0, 0, 1'b0, 2'b00);

        // Pin the model against hand-derived results.
        chk("model_3_2", ref_div(32'h6000_0000, 127, 1'b0, 2'b00), {3'b000, 32'h3FC0_0000});
        chk("model_lsh", ref_div(32'h3000_0000, 128, 1'b0, 2'b00), {3'b000, 32'h3FC0_0000});
        chk("model_carry", ref_div(32'h7FFF_FFFF, 127, 1'b0, 2'b00), {3'b001, 32'h4000_0000});
        chk("model_ovf", ref_div(32'h7FFF_FFFF, 254, 1'b0, 2'b00), {3'b101, 32'h7F80_0000});
        chk("model_unf", ref_div(32'h4000_0000, 0, 1'b1, 2'b00), {3'b011, 32'h8000_0000});
        chk("model_tie_even", ref_div(32'h4000_0040, 127, 1'b0, 2'b00), {3'b001, 32'h3F80_0000});
        chk("model_tie_odd", ref_div(32'h4000_00C0, 127, 1'b0, 2'b00), {3'b001, 32'h3F80_0002});

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_valid", bus.out_valid, 1'b0);
        chk("reset_result", bus.result, 32'h0);
        clrn = 1'b1;

        op(32'h6000_0000, fdiv_pkg::BIAS, 1'b0, 2'b00, 32'h3FC0_0000, 3'b000);
        op(32'h3000_0000, 128, 1'b0, 2'b00, 32'h3FC0_0000, 3'b000);
        op(32'h7FFF_FFFF, 127, 1'b0, 2'b00, 32'h4000_0000, 3'b001);
        op(32'h7FFF_FFFF, 254, 1'b0, 2'b00, 32'h7F80_0000, 3'b101);
        op(32'h4000_0000, 0, 1'b1, 2'b00, 32'h8000_0000, 3'b011);
        op(32'h4000_0000, 127, 1'b0, 2'b11, 32'h7FC0_0000, 3'b000);
        op(32'h4000_0000, 127, 1'b1, 2'b01, 32'h8000_0000, 3'b000);
        op(32'h4000_0000, 127, 1'b1, 2'b10, 32'hFF80_0000, 3'b000);

        // Backpressure with extra q_ready pulses while busy.
        @(negedge clk);
        drive(32'h6000_0000, 127, 1'b0, 2'b00);
        bus.q_ready   = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        drive(32'h4000_0000, 100, 1'b1, 2'b00);
        @(negedge clk);
        bus.q_ready = 1'b0;
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            bus.q_ready = (i == 2);
            @(negedge clk);
            chk("bp_valid", bus.out_valid, 1'b1);
            chk("bp_hold", bus.result, 32'h3FC0_0000);
        end
        bus.q_ready   = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_busy", bus.busy, 1'b0);
        chk("bp_release_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        chk("bp_no_capture", bus.busy, 1'b0);

        // Reset while in ROUND discards the operation.
        drive(32'h5000_0000, 130, 1'b1, 2'b00);
        bus.q_ready = 1'b1;
        @(negedge clk);
        bus.q_ready = 1'b0;
        @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_flags", bus.flags, 3'b000);
        clrn = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) n++;
        end
        chk("rst_no_output", n, 0);

        // Random traffic with random backpressure; exponents lean towards range edges.
        acc0 = n_acc;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) e = 254 + int'($urandom_range(0, 2)) - 1;
            else if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, 3)) - 1;
            else e = int'($urandom_range(0, 300)) - 20;
            drive($urandom_range(32'h2000_0000, 32'h7FFF_FFFF), e, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(0, 3)));
            bus.q_ready   = ($urandom_range(0, 2) == 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
        end
        bus.q_ready   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("random_ops_accepted", (n_acc - acc0) > 50, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
